rsa_stream_driver: RTL and testbench
====================================

// Module: rsa_stream_driver
// PURPOSE
// Initiator side of the RSA exponentiation core's start/valid interface. Holds a loaded key (expo, N),
// accepts plaintext words on a valid/ready stream, launches one core operation per word, and returns
// each result (base^expo mod N) on an output valid/ready stream. Sits between the host/UART side and the core.
// PARAMETERS
// base_width  4   message (base) width; equals core base_width
// expo_width  4   exponent width; equals core expo_width
// N_width     4   modulus/result width; equals core N_width
// START_CYC   2   cycles core_start is held high per launch (legal range >=1)
// TIMEOUT     64  max WAIT cycles before abort (>=2**expo_width+4)
// PORTS
// clk         in   1           single clock, rising edge
// rst         in   1           synchronous reset, active high
// key_load    in   1           load key_expo/key_N; accepted only when key_ready=1
// key_expo    in   expo_width  exponent to load
// key_N       in   N_width     modulus to load
// key_ready   out  1           1 in IDLE only
// msg_valid   in   1           plaintext word available
// msg_data    in   base_width  plaintext word (base)
// msg_ready   out  1           1 in IDLE when key_load=0
// ct_valid    out  1           result word available
// ct_data     out  N_width     result word; 0 when ct_err=1
// ct_err      out  1           qualifies ct_data: 1 = core timed out
// ct_ready    in   1           consumer accepts ct word
// core_start  out  1           to core start (1 = core held in reset)
// core_base   out  base_width  to core base; stable for whole operation
// core_expo   out  expo_width  to core expo; stable while key held
// core_N      out  N_width     to core N; stable while key held
// core_valid  in   1           core done/valid
// core_result in   N_width     core result, sampled only when core_valid=1 in WAIT
// BEHAVIOUR
// - Reset: state IDLE; core_start=1; ct_valid=0, ct_err=0, ct_data=0; key regs expo=0, N=0; core_base=0.
// - Key regs drive core_expo/core_N directly; base reg drives core_base; all change only in IDLE.
// - FSM IDLE -> LAUNCH -> WAIT -> HOLD -> IDLE.
//   IDLE:   core_start=1. key_load=1: latch key, stay IDLE, msg_ready=0 that cycle (key wins over msg).
//           else msg_valid=1: latch msg_data into base reg, -> LAUNCH.
//   LAUNCH: core_start=1 for exactly START_CYC cycles (cycle counter), then -> WAIT.
//   WAIT:   core_start=0; timeout counter starts at 0, increments each cycle.
//           core_valid=1: ct_data<=core_result, ct_err<=0, -> HOLD (takes priority over timeout same cycle).
//           else counter==TIMEOUT-1: ct_data<=0, ct_err<=1, -> HOLD.
//   HOLD:   core_start=1; ct_valid=1; ct_data/ct_err stable until ct_ready=1; then ct_valid<=0, -> IDLE.
// - Latency: msg accept edge -> ct_valid = START_CYC + core_cycles + 1 cycles; one op in flight max.
// - No lookahead: msg_ready=0 in LAUNCH/WAIT/HOLD; next msg accepted earliest the cycle after ct handshake.
// - Special cases (N<2, expo=0) need no driver logic: core asserts valid immediately after start drops.
// - core_valid ignored outside WAIT (stale done from previous op is irrelevant while start=1).
// - rst mid-operation: returns to IDLE with reset values next edge; pending ct word and key are lost.
// - Counter widths: $clog2(START_CYC+1) and $clog2(TIMEOUT+1); no wrap possible.
// STRUCTURE
// - Shared package rsa_pkg: state enum (IDLE, LAUNCH, WAIT, HOLD), default widths shared with core.
// - No sub-module required; optional rsa_out_reg (1-entry valid/ready holding register) if reused elsewhere.
// TESTING
// - key expo=3 N=11; msg 4 -> ct_data=9, ct_err=0; ct_valid exactly START_CYC+core latency+1 after accept.
// - key expo=0 N=11; msg 5 -> ct_data=1. key expo=5 N=1; msg 7 -> ct_data=0.
// - key expo=2 N=13; msgs 2,3,4 back-to-back, ct_ready=1 -> 4,9,3 in order, msg_ready only in IDLE.
// - ct_ready=0 for 10 cycles in HOLD -> ct_valid/ct_data stable, msg_ready=0, core_start=1 throughout.
// - core model never asserts valid -> ct_valid with ct_err=1, ct_data=0 after exactly TIMEOUT WAIT cycles.
// - key_load and msg_valid same IDLE cycle -> key latched, msg accepted next cycle using new key;
//   rst pulsed mid-WAIT -> next cycle IDLE, core_start=1, ct_valid=0, key regs cleared to 0.

Source files
------------

// File: rtl/rsa_pkg.sv
// -----------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the RSA exponentiation core and its stream driver:
// the driver FSM state encoding and the default operand widths, which must
// match the widths the core itself is built with.
// -----------------------------------------------------------------------------
package rsa_pkg;

  // Driver sequencing: wait for a word, hold the core in start while the
  // operands settle, wait for done (or give up), then present the result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // Default widths shared with the exponentiation core.
  localparam int unsigned DEF_BASE_W    = 4;
  localparam int unsigned DEF_EXPO_W    = 4;
  localparam int unsigned DEF_N_W       = 4;

  // Default launch length and abort limit.  The abort limit must cover the
  // worst-case core latency (one step per exponent value plus overhead).
  localparam int unsigned DEF_START_CYC = 2;
  localparam int unsigned DEF_TIMEOUT   = 64;

endpackage : rsa_pkg

// File: rtl/rsa_stream_driver.sv
// -----------------------------------------------------------------------------
// rsa_stream_driver
// Initiator side of the RSA exponentiation core.  Holds a loaded key
// (exponent, modulus), takes plaintext words from a valid/ready stream,
// runs one core operation per word and returns base^expo mod N on an output
// valid/ready stream.  Exactly one operation is in flight at a time.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   key_load          load key_expo/key_N (honoured only while key_ready=1)
//   key_expo, key_N   key to load
//   key_ready         high in IDLE only
//   msg_valid/ready   plaintext stream handshake (ready only in IDLE, and not
//                     while a key load is being presented)
//   msg_data          plaintext word, becomes the core base
//   ct_valid/ready    result stream handshake
//   ct_data           result word, forced to 0 when ct_err=1
//   ct_err            1 = core did not finish within TIMEOUT cycles
//   core_start        core start (1 holds the core in reset)
//   core_base/expo/N  core operands, stable for the whole operation
//   core_valid        core done
//   core_result       core result, sampled only on core_valid in WAIT
// -----------------------------------------------------------------------------
module rsa_stream_driver
  import rsa_pkg::*;
#(
  parameter int unsigned base_width = DEF_BASE_W,
  parameter int unsigned expo_width = DEF_EXPO_W,
  parameter int unsigned N_width    = DEF_N_W,
  parameter int unsigned START_CYC  = DEF_START_CYC,  // >= 1
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT     // >= 2**expo_width + 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  key_load,
  input  logic [expo_width-1:0] key_expo,
  input  logic [N_width-1:0]    key_N,
  output logic                  key_ready,

  input  logic                  msg_valid,
  input  logic [base_width-1:0] msg_data,
  output logic                  msg_ready,

  output logic                  ct_valid,
  output logic [N_width-1:0]    ct_data,
  output logic                  ct_err,
  input  logic                  ct_ready,

  output logic                  core_start,
  output logic [base_width-1:0] core_base,
  output logic [expo_width-1:0] core_expo,
  output logic [N_width-1:0]    core_N,
  input  logic                  core_valid,
  input  logic [N_width-1:0]    core_result
);

  // Counters are sized to hold their terminal count, so they never wrap.
  localparam int unsigned LC_W = $clog2(START_CYC + 1);
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  localparam logic [LC_W-1:0] LC_LAST = LC_W'(START_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e                  state_q;
  logic [LC_W-1:0]         lc_q;        // cycles spent in LAUNCH
  logic [TO_W-1:0]         to_q;        // cycles spent in WAIT
  logic                    core_start_q;
  logic                    ct_valid_q;
  logic                    ct_err_q;
  logic [N_width-1:0]      ct_data_q;
  logic [expo_width-1:0]   expo_q;
  logic [N_width-1:0]      n_q;
  logic [base_width-1:0]   base_q;

  // Handshake readies are pure decodes of the state.  A key load in the same
  // cycle as a message wins, so the message is held off until the next cycle
  // and then runs with the new key.
  always_comb begin
    key_ready = (state_q == IDLE);
    msg_ready = (state_q == IDLE) && !key_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lc_q         <= '0;
      to_q         <= '0;
      core_start_q <= 1'b1;
      ct_valid_q   <= 1'b0;
      ct_err_q     <= 1'b0;
      ct_data_q    <= '0;
      expo_q       <= '0;
      n_q          <= '0;
      base_q       <= '0;
    end else begin
      case (state_q)
        // ---- IDLE: accept a key or a plaintext word ----
        IDLE: begin
          core_start_q <= 1'b1;
          if (key_load) begin
            expo_q <= key_expo;
            n_q    <= key_N;
          end else if (msg_valid) begin
            base_q  <= msg_data;
            lc_q    <= '0;
            state_q <= LAUNCH;
          end
        end

        // ---- LAUNCH: keep the core in start while the new base settles ----
        LAUNCH: begin
          if (lc_q == LC_LAST) begin
            core_start_q <= 1'b0;
            to_q         <= '0;
            state_q      <= WAIT;
          end else begin
            lc_q <= lc_q + LC_W'(1);
          end
        end

        // ---- WAIT: core running; a done in the last allowed cycle still
        //      counts as a good result rather than a timeout ----
        WAIT: begin
          if (core_valid) begin
            ct_data_q    <= core_result;
            ct_err_q     <= 1'b0;
            ct_valid_q   <= 1'b1;
            core_start_q <= 1'b1;
            state_q      <= HOLD;
          end else if (to_q == TO_LAST) begin
            ct_data_q    <= '0;
            ct_err_q     <= 1'b1;
            ct_valid_q   <= 1'b1;
            core_start_q <= 1'b1;
            state_q      <= HOLD;
          end else begin
            to_q <= to_q + TO_W'(1);
          end
        end

        // ---- HOLD: present the result until the consumer takes it ----
        HOLD: begin
          core_start_q <= 1'b1;
          if (ct_ready) begin
            ct_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end

        default: begin
          core_start_q <= 1'b1;
          ct_valid_q   <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign core_start = core_start_q;
  assign core_base  = base_q;
  assign core_expo  = expo_q;
  assign core_N     = n_q;
  assign ct_valid   = ct_valid_q;
  assign ct_data    = ct_data_q;
  assign ct_err     = ct_err_q;

endmodule : rsa_stream_driver

// File: tb/tb_rsa_stream_driver.sv
// -----------------------------------------------------------------------------
// tb_rsa_stream_driver
// Directed bench for rsa_stream_driver with a behavioural stand-in for the
// exponentiation core: it raises done a programmable number of cycles after
// start drops (or never), and returns base^expo mod N.
// -----------------------------------------------------------------------------
module tb_rsa_stream_driver;

  localparam int START_CYC = 2;
  localparam int TIMEOUT   = 64;
  localparam int LIMIT     = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_load;
  logic [3:0] key_expo;
  logic [3:0] key_N;
  logic       key_ready;
  logic       msg_valid;
  logic [3:0] msg_data;
  logic       msg_ready;
  logic       ct_valid;
  logic [3:0] ct_data;
  logic       ct_err;
  logic       ct_ready;
  logic       core_start;
  logic [3:0] core_base;
  logic [3:0] core_expo;
  logic [3:0] core_N;
  logic       core_valid;
  logic [3:0] core_result;

  int n_cmp = 0;
  int n_err = 0;

  // Core stand-in controls
  int core_lat  = 0;
  bit core_dead = 1'b0;
  int ccnt;

  always #5 clk = ~clk;

  rsa_stream_driver #(
    .base_width(4), .expo_width(4), .N_width(4),
    .START_CYC(START_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .key_load(key_load), .key_expo(key_expo), .key_N(key_N), .key_ready(key_ready),
    .msg_valid(msg_valid), .msg_data(msg_data), .msg_ready(msg_ready),
    .ct_valid(ct_valid), .ct_data(ct_data), .ct_err(ct_err), .ct_ready(ct_ready),
    .core_start(core_start), .core_base(core_base), .core_expo(core_expo),
    .core_N(core_N), .core_valid(core_valid), .core_result(core_result)
  );

  function automatic int modexp(input int b, input int e, input int m);
    int r;
    if (m == 0) return 0;
    r = 1 % m;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return r;
  endfunction

  // ccnt = number of cycles since start dropped (0 in the first cycle).
  always @(posedge clk) begin
    if (core_start) ccnt <= 0;
    else            ccnt <= ccnt + 1;
  end

  always_comb begin
    core_valid  = !core_start && !core_dead && (ccnt == core_lat);
    core_result = 4'(modexp(int'(core_base), int'(core_expo), int'(core_N)));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge.
  task automatic load_key(input string tag, input logic [3:0] e, input logic [3:0] n);
    key_load = 1'b1; key_expo = e; key_N = n;
    #1;
    chk({tag, ".key_ready"}, key_ready, 1);
    chk({tag, ".msg_ready_blocked"}, msg_ready, 0);
    @(negedge clk);
    key_load = 1'b0;
    chk({tag, ".core_expo"}, core_expo, e);
    chk({tag, ".core_N"}, core_N, n);
  endtask

  // Push one word, measure accept->ct_valid latency, optionally stall the
  // consumer for 'hold' cycles, then complete the output handshake.
  task automatic run_op(input string tag, input logic [3:0] m, input int exp_data,
                        input int exp_err, input int exp_lat, input int hold);
    int n;
    int bad;
    msg_valid = 1'b1; msg_data = m;
    #1;
    chk({tag, ".msg_ready"}, msg_ready, 1);
    @(negedge clk);
    msg_valid = 1'b0; msg_data = 4'd0;
    chk({tag, ".core_base"}, core_base, m);
    n = 0; bad = 0;
    while (ct_valid !== 1'b1 && n < LIMIT) begin
      if (msg_ready !== 1'b0 || key_ready !== 1'b0) bad++;
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, n, exp_lat);
    chk({tag, ".ready_busy"}, bad, 0);
    chk({tag, ".ct_data"}, ct_data, exp_data);
    chk({tag, ".ct_err"}, ct_err, exp_err);
    chk({tag, ".start_hold"}, core_start, 1);
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ct_valid !== 1'b1 || ct_data !== 4'(exp_data) || ct_err !== 1'(exp_err) ||
          msg_ready !== 1'b0 || core_start !== 1'b1) bad++;
    end
    if (hold > 0) chk({tag, ".hold_stable"}, bad, 0);
    ct_ready = 1'b1;
    @(negedge clk);
    ct_ready = 1'b0;
    chk({tag, ".ct_valid_drop"}, ct_valid, 0);
    chk({tag, ".msg_ready_idle"}, msg_ready, 1);
  endtask

  initial begin
    rst = 1'b1; key_load = 1'b0; key_expo = 4'd0; key_N = 4'd0;
    msg_valid = 1'b0; msg_data = 4'd0; ct_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.core_start", core_start, 1);
    chk("rst.ct_valid", ct_valid, 0);
    chk("rst.ct_err", ct_err, 0);
    chk("rst.ct_data", ct_data, 0);
    chk("rst.core_expo", core_expo, 0);
    chk("rst.core_N", core_N, 0);
    chk("rst.core_base", core_base, 0);
    chk("rst.key_ready", key_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // 4^3 mod 11 = 64 mod 11 = 9; latency 2 + 3 + 1 = 6
    core_lat = 3;
    load_key("k3_11", 4'd3, 4'd11);
    run_op("m4", 4'd4, 9, 0, 6, 0);

    // 5^0 mod 11 = 1; latency 2 + 0 + 1 = 3
    core_lat = 0;
    load_key("k0_11", 4'd0, 4'd11);
    run_op("m5e0", 4'd5, 1, 0, 3, 0);

    // 7^5 mod 1 = 0
    load_key("k5_1", 4'd5, 4'd1);
    run_op("m7n1", 4'd7, 0, 0, 3, 0);

    // expo 2, N 13: 2->4, 3->9, 4->16 mod 13=3; latency 2 + 1 + 1 = 4
    core_lat = 1;
    load_key("k2_13", 4'd2, 4'd13);
    run_op("b2b_2", 4'd2, 4, 0, 4, 0);
    run_op("b2b_3", 4'd3, 9, 0, 4, 0);
    run_op("b2b_4", 4'd4, 3, 0, 4, 0);

    // Consumer stalls 10 cycles: 3^2 mod 13 = 9; latency 2 + 2 + 1 = 5
    core_lat = 2;
    run_op("stall", 4'd3, 9, 0, 5, 10);

    // Core never finishes: error after 64 WAIT cycles, latency 2 + 64 = 66
    core_dead = 1'b1;
    run_op("tmo", 4'd6, 0, 1, 66, 0);
    core_dead = 1'b0;

    // Key and message presented together: key wins, message runs next cycle
    // with the new key.  5^3 mod 11 = 125 mod 11 = 4
    core_lat = 0;
    key_load = 1'b1; key_expo = 4'd3; key_N = 4'd11;
    msg_valid = 1'b1; msg_data = 4'd5;
    #1;
    chk("kmsg.msg_ready", msg_ready, 0);
    @(negedge clk);
    key_load = 1'b0;
    chk("kmsg.still_idle", key_ready, 1);
    chk("kmsg.core_expo", core_expo, 3);
    chk("kmsg.core_N", core_N, 11);
    run_op("kmsg", 4'd5, 4, 0, 3, 0);

    // Reset in the middle of WAIT
    core_dead = 1'b1;
    msg_valid = 1'b1; msg_data = 4'd9;
    @(negedge clk);
    msg_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstw.in_wait", core_start, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw.core_start", core_start, 1);
    chk("rstw.ct_valid", ct_valid, 0);
    chk("rstw.key_ready", key_ready, 1);
    chk("rstw.core_expo", core_expo, 0);
    chk("rstw.core_N", core_N, 0);
    chk("rstw.core_base", core_base, 0);
    core_dead = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rsa_stream_driver
